// File: rtl/wb_stage.sv
// Writeback stage: formats the result, drives the regfile write port, and tracks pending-write registers.
// Latency 1: an instruction accepted at edge k drives o_we/o_rd/o_rd_data after edge k.
// Backpressure: i_wb_stall with a pending write holds the outputs and drops o_ready.
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rd,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_wb_stall,
    input  logic            i_issue,
    input  logic [4:0]      i_issue_rd,
    output logic            o_we,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_rd_data,
    output logic [31:0]     o_busy,
    output logic            o_illegal,
    output logic [31:0]     o_retired
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;

    logic            accept;
    logic            commit;
    logic            has_result;
    logic            wr_en;
    logic            bad_load;
    logic [XLEN-1:0] result;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     set_mask;
    logic [31:0]     clr_mask;
    logic [31:0]     busy_next;

    // A pending write that cannot drain blocks new instructions.
    assign o_ready = !(o_we && i_wb_stall);
    assign accept  = i_valid && o_ready;
    assign commit  = o_we && !i_wb_stall;

    // Pick the addressed byte and halfword out of the aligned load word.
    always_comb begin
        ld_byte = i_mem_rdata[7:0];
        case (i_alu_result[1:0])
            2'd0: ld_byte = i_mem_rdata[7:0];
            2'd1: ld_byte = i_mem_rdata[15:8];
            2'd2: ld_byte = i_mem_rdata[23:16];
            2'd3: ld_byte = i_mem_rdata[31:24];
            default: ld_byte = i_mem_rdata[7:0];
        endcase
        ld_half = i_alu_result[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    end

    // Result select; non-writing opcodes and undefined loads leave has_result low.
    always_comb begin
        result     = '0;
        has_result = 1'b0;
        bad_load   = 1'b0;
        case (i_opcode)
            OP_R, OP_I, AUIPC: begin
                has_result = 1'b1;
                result     = i_alu_result;
            end
            LUI: begin
                has_result = 1'b1;
                result     = i_imm;
            end
            JAL, JALR: begin
                has_result = 1'b1;
                result     = i_pc + 32'd4;
            end
            LOAD: begin
                has_result = 1'b1;
                case (i_funct3)
                    3'b000:  result = {{24{ld_byte[7]}}, ld_byte};
                    3'b100:  result = {24'd0, ld_byte};
                    3'b001:  result = {{16{ld_half[15]}}, ld_half};
                    3'b101:  result = {16'd0, ld_half};
                    3'b010:  result = i_mem_rdata;
                    default: begin
                        has_result = 1'b0;
                        bad_load   = 1'b1;
                    end
                endcase
            end
            default: has_result = 1'b0;
        endcase
    end

    // x0 is hardwired, so a write to it is dropped but the instruction still retires.
    assign wr_en = has_result && (i_rd != 5'd0);

    // Scoreboard update: an issue in the same cycle as the commit of that register wins.
    assign set_mask  = i_issue ? (32'd1 << i_issue_rd) : 32'd0;
    assign clr_mask  = commit ? (32'd1 << o_rd) : 32'd0;
    assign busy_next = ((o_busy & ~clr_mask) | set_mask) & ~32'd1;

    // Pending write register: load on accept, drop after commit, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_we      <= 1'b0;
            o_rd      <= 5'd0;
            o_rd_data <= '0;
        end else if (accept) begin
            o_we <= wr_en;
            if (wr_en) begin
                o_rd      <= i_rd;
                o_rd_data <= result;
            end
        end else if (commit) begin
            o_we <= 1'b0;
        end
    end

    // Scoreboard, illegal-load pulse and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_busy    <= 32'd0;
            o_illegal <= 1'b0;
            o_retired <= 32'd0;
        end else begin
            o_busy    <= busy_next;
            o_illegal <= accept && (i_opcode == LOAD) && bad_load;
            if (accept) begin
                o_retired <= o_retired + 32'd1;
            end
        end
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RISC-V CPU pipeline and the write-side counterpart of the decode-stage register file read path. It accepts completed instructions from the memory stage, selects and formats the result (ALU result, load data, link address, immediate), and drives the register file write port (`we`, `rd`, `rd_data`). It also keeps a per-register pending-write scoreboard that decode uses to stall on RAW hazards.

## Interface
- `XLEN`, 32, data width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_valid`  in  1  memory-stage instruction valid.
- `o_ready`  out  1  stage can accept an instruction this cycle.
- `i_opcode`  in  7  instruction opcode[6:0].
- `i_funct3`  in  3  instruction funct3.
- `i_rd`  in  5  destination register.
- `i_alu_result`  in  32  EX result; for loads, the effective address.
- `i_mem_rdata`  in  32  aligned 32-bit word read from data memory.
- `i_pc`  in  32  instruction PC.
- `i_imm`  in  32  decoded immediate.
- `i_wb_stall`  in  1  register file write port busy; hold the pending write.
- `i_issue`  in  1  decode issued an instruction that writes `i_issue_rd`.
- `i_issue_rd`  in  5  destination of the issued instruction.
- `o_we`  out  1  register file write enable.
- `o_rd`  out  5  register file write address.
- `o_rd_data`  out  32  register file write data.
- `o_busy`  out  32  scoreboard; bit n=1 means a write to xn is pending.
- `o_illegal`  out  1  one-cycle pulse for an undefined load funct3.
- `o_retired`  out  32  count of accepted instructions.

## Operation
- Accept when `i_valid && o_ready`. `o_ready = !(o_we && i_wb_stall)`.
- Result select by `i_opcode`:
  - OP_R (0110011), OP_I (0010011), AUIPC (0010111): `i_alu_result`.
  - LUI (0110111): `i_imm`.
  - JAL (1101111), JALR (1100111): `i_pc + 4`, modulo 2^32.
  - LOAD (0000011): formatted load data (see below).
  - OP_B (1100011), OP_S (0100011), and any other opcode: no write.
- Load formatting uses offset `off = i_alu_result[1:0]`:
  - LB (000) and LBU (100): byte `i_mem_rdata[8*off+7 : 8*off]`, sign-extended for LB, zero-extended for LBU.
  - LH (001) and LHU (101): halfword at `off[1]` (0 → [15:0], 1 → [31:16]), sign- or zero-extended; `off[0]` is ignored.
  - LW (010): the full word; `off` is ignored.
  - Funct3 011, 110, 111: no write, and `o_illegal` pulses.
- `i_rd == 0` never produces a write, but the instruction is still retired.
- Writing opcodes capture `o_we = 1`, `o_rd = i_rd`, `o_rd_data = result`. Non-writing opcodes capture `o_we = 0`; `o_rd` and `o_rd_data` are left unchanged.
- Commit happens when `o_we && !i_wb_stall`. After commit, `o_we` drops next cycle unless a new writing instruction is accepted.
- Scoreboard, per bit n = 1..31:
  - Set when `i_issue && i_issue_rd == n`.
  - Clear on commit with `o_rd == n`.
  - Set and clear in the same cycle: set wins.
  - `o_busy[0]` is constant 0; an issue to x0 is ignored.
- `o_retired` increments by 1 per accepted instruction, writing or not, and wraps from 0xFFFFFFFF to 0.

## Timing
- Latency 1: an instruction accepted at edge k has `o_we`, `o_rd` and `o_rd_data` valid after edge k; the regfile writes at edge k+1 if not stalled.
- While `i_wb_stall = 1` and `o_we = 1`: outputs hold, `o_ready = 0`, and the busy bit stays set.
- Back-to-back writes at one per cycle are supported when there is no stall.
- `o_illegal` is registered and is high for exactly the cycle after the bad load is accepted.
- Reset (asynchronous, any time including mid-stall) clears the pending write immediately:
  - `o_we = 0`, `o_rd = 0`, `o_rd_data = 0`
  - `o_busy = 0`, `o_illegal = 0`, `o_retired = 0`
  - `o_ready = 1`

## Test plan
- **ADD result.** Issue x5 (`o_busy[5] = 1`), then accept OP_R with rd=5 and alu=0x0000_1234.
  - Next cycle: `o_we = 1`, `o_rd = 5`, `o_rd_data = 0x1234`.
  - Cycle after: `o_busy[5] = 0`, `o_retired = 1`.
- **Loads, with `i_mem_rdata = 0x80FF_7F01`.**
  - LB, off=2: `o_rd_data = 0xFFFF_FFFF`.
  - LBU, off=3: `0x0000_0080`.
  - LH, off=2: `0xFFFF_80FF`.
  - LHU, off=0: `0x0000_7F01`.
  - LW, off=1: `0x80FF_7F01`.
- **Link, LUI, and no-write cases.**
  - JAL, pc=0xFFFF_FFFC, rd=1: writes 0x0000_0000 (wraps).
  - LUI, imm=0xABCD_E000: writes 0xABCD_E000.
  - OP_S, and OP_R with rd=0: `o_we = 0`, and `o_retired` still increments.
- **Stall.** Hold `i_wb_stall = 1` for 3 cycles with `o_we = 1` and rd=7.
  - Outputs are stable, `o_ready = 0`, `o_busy[7] = 1`.
  - On release the write commits and `o_busy[7]` clears one cycle later.
- **Scoreboard race.** In the same cycle, commit x9 and issue x9: `o_busy[9]` remains 1. Issue x0: `o_busy[0]` stays 0.
- **Illegal load and mid-stall reset.**
  - Load funct3=110: `o_illegal` is high for 1 cycle and `o_we = 0`.
  - Assert `rst` mid-stall: all outputs are 0 immediately, and `o_ready = 1`.
